// File: rtl/riscv_tag_wb_stage.sv
// Load writeback stage with DIFT tag propagation.
// Takes a load from EX, waits for LSU read data and its memory tag, and
// merges that tag with the load-address tag under the policy chosen at
// handoff. It then writes data and tag to the register file for one cycle.
// EX tag-check violations become a held trap request towards the
// controller, and a saturating counter records every violation.
module riscv_tag_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        ex_addr_tag_i,
    input  logic        ex_exception_tag_i,
    input  logic [31:0] ex_pc_i,
    input  logic [1:0]  load_mode_i,
    input  logic        flush_i,
    output logic        wb_ready_o,
    input  logic        lsu_rvalid_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        lsu_rdata_tag_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_wdata_tag_o,
    output logic        tag_trap_o,
    output logic [31:0] tag_trap_pc_o,
    input  logic        tag_trap_ack_i,
    output logic [15:0] tag_viol_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Load tag policies
    localparam logic [1:0] MODE_MEM = 2'd0;
    localparam logic [1:0] MODE_OR  = 2'd1;
    localparam logic [1:0] MODE_AND = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic        accept;
    logic        data_arrive;
    logic        viol_event;
    logic        tag_next;

    logic        rf_we_reg;
    logic [4:0]  waddr_reg;
    logic        addr_tag_reg;
    logic [1:0]  mode_reg;
    logic [31:0] wdata_reg;
    logic        wtag_reg;
    logic        trap_reg;
    logic [31:0] trap_pc_reg;
    logic [15:0] viol_cnt_reg;

    // Only WAIT blocks a handoff. WRITE can accept, so back-to-back loads work.
    assign wb_ready_o  = (state_reg != ST_WAIT);
    assign accept      = ex_valid_i & ex_load_i & wb_ready_o & ~flush_i;
    // Read data counts only for a live, unflushed load.
    assign data_arrive = (state_reg == ST_WAIT) & lsu_rvalid_i & ~flush_i;
    assign viol_event  = ex_valid_i & ex_exception_tag_i;

    // Next-state decode for the load sequencer
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = accept ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (flush_i)
                    state_next = ST_IDLE;
                else if (lsu_rvalid_i)
                    state_next = ST_WRITE;
                else
                    state_next = ST_WAIT;
            end
            ST_WRITE: state_next = accept ? ST_WAIT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Merge the memory tag with the latched address tag under the load policy
    always_comb begin
        tag_next = 1'b0;
        case (mode_reg)
            MODE_MEM: tag_next = lsu_rdata_tag_i;
            MODE_OR:  tag_next = lsu_rdata_tag_i | addr_tag_reg;
            MODE_AND: tag_next = lsu_rdata_tag_i & addr_tag_reg;
            default:  tag_next = 1'b0;
        endcase
    end

    // State register and write strobe. rf_we is high exactly in WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rf_we_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rf_we_reg <= data_arrive;
        end
    end

    // Capture the load context at handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_reg    <= 5'd0;
            addr_tag_reg <= 1'b0;
            mode_reg     <= 2'd0;
        end else if (accept) begin
            waddr_reg    <= ex_waddr_i;
            addr_tag_reg <= ex_addr_tag_i;
            mode_reg     <= load_mode_i;
        end
    end

    // Capture read data and its propagated tag when the LSU answers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_reg <= 32'd0;
            wtag_reg  <= 1'b0;
        end else if (data_arrive) begin
            wdata_reg <= lsu_rdata_i;
            wtag_reg  <= tag_next;
        end
    end

    // Trap request: the first event arms it. Later events are dropped until
    // acknowledged. An ack together with a new event re-arms it with the new PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_reg    <= 1'b0;
            trap_pc_reg <= 32'd0;
        end else if (!trap_reg) begin
            if (viol_event) begin
                trap_reg    <= 1'b1;
                trap_pc_reg <= ex_pc_i;
            end
        end else if (tag_trap_ack_i) begin
            if (viol_event)
                trap_pc_reg <= ex_pc_i;
            else
                trap_reg    <= 1'b0;
        end
    end

    // Violation counter: counts every event, including dropped ones, and sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            viol_cnt_reg <= 16'd0;
        else if (viol_event && (viol_cnt_reg != 16'hFFFF))
            viol_cnt_reg <= viol_cnt_reg + 16'd1;
    end

    assign rf_we_o        = rf_we_reg;
    assign rf_waddr_o     = waddr_reg;
    assign rf_wdata_o     = wdata_reg;
    assign rf_wdata_tag_o = wtag_reg;
    assign tag_trap_o     = trap_reg;
    assign tag_trap_pc_o  = trap_pc_reg;
    assign tag_viol_cnt_o = viol_cnt_reg;

endmodule

// File: tb/tb_riscv_tag_wb_stage.sv
// Bench for riscv_tag_wb_stage. A transaction-level reference model runs
// cycle by cycle. Directed steps cover the listed scenarios, followed by a
// randomized phase.
module tb_riscv_tag_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid_i, ex_load_i, ex_addr_tag_i, ex_exception_tag_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_pc_i;
    logic [1:0]  load_mode_i;
    logic        flush_i;
    logic        wb_ready_o;
    logic        lsu_rvalid_i, lsu_rdata_tag_i;
    logic [31:0] lsu_rdata_i;
    logic        rf_we_o, rf_wdata_tag_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        tag_trap_o, tag_trap_ack_i;
    logic [31:0] tag_trap_pc_o;
    logic [15:0] tag_viol_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state. A load is either outstanding, waiting for data,
    // or complete with its register-file write due.
    bit          m_busy;
    logic [4:0]  m_addr;
    logic        m_atag;
    logic [1:0]  m_mode;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_wtag;
    bit          m_trap;
    logic [31:0] m_pc;
    int          m_cnt;

    riscv_tag_wb_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_load_i(ex_load_i), .ex_waddr_i(ex_waddr_i),
        .ex_addr_tag_i(ex_addr_tag_i), .ex_exception_tag_i(ex_exception_tag_i),
        .ex_pc_i(ex_pc_i), .load_mode_i(load_mode_i), .flush_i(flush_i),
        .wb_ready_o(wb_ready_o), .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
        .lsu_rdata_tag_i(lsu_rdata_tag_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .rf_wdata_tag_o(rf_wdata_tag_o), .tag_trap_o(tag_trap_o),
        .tag_trap_pc_o(tag_trap_pc_o), .tag_trap_ack_i(tag_trap_ack_i),
        .tag_viol_cnt_o(tag_viol_cnt_o)
    );

    always #5 clk = ~clk;

    // Truth table for the load tag policy
    function automatic logic policy_tag(input logic [1:0] mode, input logic m, input logic a);
        case (mode)
            2'd0:    return m;
            2'd1:    return m | a;
            2'd2:    return m & a;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ex_valid_i = 0; ex_load_i = 0; ex_waddr_i = 0; ex_addr_tag_i = 0;
        ex_exception_tag_i = 0; ex_pc_i = 0; load_mode_i = 0; flush_i = 0;
        lsu_rvalid_i = 0; lsu_rdata_i = 0; lsu_rdata_tag_i = 0; tag_trap_ack_i = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_addr = 0; m_atag = 0; m_mode = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0; m_wtag = 0;
        m_trap = 0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic check_all();
        chk("wb_ready", {31'd0, wb_ready_o}, {31'd0, !m_busy});
        chk("rf_we", {31'd0, rf_we_o}, {31'd0, m_we});
        if (m_we) begin
            chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, m_waddr});
            chk("rf_wdata", rf_wdata_o, m_wdata);
            chk("rf_wtag", {31'd0, rf_wdata_tag_o}, {31'd0, m_wtag});
        end
        chk("trap", {31'd0, tag_trap_o}, {31'd0, m_trap});
        if (m_trap)
            chk("trap_pc", tag_trap_pc_o, m_pc);
        chk("viol_cnt", {16'd0, tag_viol_cnt_o}, m_cnt[31:0]);
    endtask

    // One clock: advance the model on the inputs the DUT sampled, then compare
    task automatic cycle();
        bit acc, evt;
        @(posedge clk);
        acc = ex_valid_i && ex_load_i && !m_busy && !flush_i;
        if (m_busy && !flush_i && lsu_rvalid_i) begin
            m_we    = 1;
            m_waddr = m_addr;
            m_wdata = lsu_rdata_i;
            m_wtag  = policy_tag(m_mode, lsu_rdata_tag_i, m_atag);
        end else begin
            m_we = 0;
        end
        m_busy = acc || (m_busy && !flush_i && !lsu_rvalid_i);
        if (acc) begin
            m_addr = ex_waddr_i; m_atag = ex_addr_tag_i; m_mode = load_mode_i;
        end
        evt = ex_valid_i && ex_exception_tag_i;
        if (evt && m_cnt < 65535) m_cnt++;
        if (!m_trap) begin
            if (evt) begin m_trap = 1; m_pc = ex_pc_i; end
        end else if (tag_trap_ack_i) begin
            if (evt) m_pc = ex_pc_i;
            else     m_trap = 0;
        end
        #1;
        check_all();
    endtask

    // Pulse the asynchronous reset between clock edges and check outputs at once
    task automatic do_reset();
        #2 rst = 1;
        #1;
        chk("rst_ready", {31'd0, wb_ready_o}, 32'd1);
        chk("rst_we", {31'd0, rf_we_o}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_wtag", {31'd0, rf_wdata_tag_o}, 32'd0);
        chk("rst_trap", {31'd0, tag_trap_o}, 32'd0);
        chk("rst_trap_pc", tag_trap_pc_o, 32'd0);
        chk("rst_cnt", {16'd0, tag_viol_cnt_o}, 32'd0);
        model_reset();
        #1 rst = 0;
    endtask

    task automatic drive_load(input logic [4:0] wa, input logic at, input logic [1:0] mode);
        ex_valid_i = 1; ex_load_i = 1; ex_waddr_i = wa; ex_addr_tag_i = at; load_mode_i = mode;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #1;
        do_reset();

        // Single load: x5, mode 01, addr tag 1, memory tag 0
        clear_inputs(); drive_load(5'd5, 1'b1, 2'd1);
        cycle();
        chk("t1_ready_wait", {31'd0, wb_ready_o}, 32'd0);
        clear_inputs(); lsu_rvalid_i = 1; lsu_rdata_i = 32'hDEADBEEF; lsu_rdata_tag_i = 0;
        cycle();
        chk("t1_we", {31'd0, rf_we_o}, 32'd1);
        chk("t1_waddr", {27'd0, rf_waddr_o}, 32'd5);
        chk("t1_wdata", rf_wdata_o, 32'hDEADBEEF);
        chk("t1_wtag", {31'd0, rf_wdata_tag_o}, 32'd1);
        clear_inputs();
        cycle();
        chk("t1_we_once", {31'd0, rf_we_o}, 32'd0);

        // Mode sweep over every (m,a) pair, back-to-back loads accepted in WRITE
        for (int i = 0; i < 16; i++) begin
            clear_inputs();
            drive_load(5'($urandom), i[0], i[3:2]);
            cycle();
            clear_inputs();
            lsu_rvalid_i = 1; lsu_rdata_i = $urandom; lsu_rdata_tag_i = i[1];
            cycle();
        end
        clear_inputs();
        repeat (2) cycle();

        // Flush in WAIT, then a late rvalid that must be ignored
        drive_load(5'd9, 1'b1, 2'd0);
        cycle();
        clear_inputs(); flush_i = 1;
        cycle();
        clear_inputs();
        repeat (2) cycle();
        lsu_rvalid_i = 1; lsu_rdata_i = 32'h12345678; lsu_rdata_tag_i = 1;
        cycle();
        clear_inputs();
        cycle();
        chk("flush_no_we", {31'd0, rf_we_o}, 32'd0);

        // Trap sequence from a fresh counter
        do_reset();
        ex_valid_i = 1; ex_exception_tag_i = 1; ex_pc_i = 32'h100;
        cycle();
        ex_pc_i = 32'h200;
        cycle();
        chk("trap_pc_first", tag_trap_pc_o, 32'h100);
        chk("trap_cnt2", {16'd0, tag_viol_cnt_o}, 32'd2);
        ex_pc_i = 32'h300; tag_trap_ack_i = 1;
        cycle();
        chk("trap_reload", {31'd0, tag_trap_o}, 32'd1);
        chk("trap_pc_reload", tag_trap_pc_o, 32'h300);
        chk("trap_cnt3", {16'd0, tag_viol_cnt_o}, 32'd3);
        clear_inputs(); tag_trap_ack_i = 1;
        cycle();
        chk("trap_drop", {31'd0, tag_trap_o}, 32'd0);
        clear_inputs();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ex_valid_i         = 1'($urandom);
            ex_load_i          = ($urandom_range(0, 3) != 0);
            ex_waddr_i         = 5'($urandom);
            ex_addr_tag_i      = 1'($urandom);
            ex_exception_tag_i = ($urandom_range(0, 7) == 0);
            ex_pc_i            = $urandom;
            load_mode_i        = 2'($urandom);
            flush_i            = ($urandom_range(0, 9) == 0);
            lsu_rvalid_i       = ($urandom_range(0, 2) != 0);
            lsu_rdata_i        = $urandom;
            lsu_rdata_tag_i    = 1'($urandom);
            tag_trap_ack_i     = ($urandom_range(0, 2) == 0);
            cycle();
        end
        clear_inputs();
        cycle();

        // Counter saturation
        do_reset();
        ex_valid_i = 1; ex_exception_tag_i = 1; ex_pc_i = 32'h400;
        repeat (65534) cycle();
        chk("cnt_fffe", {16'd0, tag_viol_cnt_o}, 32'hFFFE);
        repeat (3) cycle();
        chk("cnt_sat", {16'd0, tag_viol_cnt_o}, 32'hFFFF);
        clear_inputs();
        repeat (2) cycle();
        chk("cnt_hold", {16'd0, tag_viol_cnt_o}, 32'hFFFF);

        // Reset while a load waits and a trap is pending
        drive_load(5'd12, 1'b1, 2'd1);
        ex_exception_tag_i = 1; ex_pc_i = 32'h500;
        cycle();
        clear_inputs();
        do_reset();
        lsu_rvalid_i = 1; lsu_rdata_i = 32'hCAFEF00D; lsu_rdata_tag_i = 1;
        cycle();
        clear_inputs();
        cycle();
        chk("rst_no_we", {31'd0, rf_we_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
